// File: rtl/perceptron_layer_seq.sv
`timescale 1ns/1ps
// perceptron_layer_seq
// Time-multiplexed layer of N_OUT binary-input perceptrons. A single signed
// accumulator walks every neuron serially: N_IN weight terms, then one bias
// term that also produces that neuron's output bit. The weights, the biases
// and the common threshold live in registers that can be written at runtime
// while the layer is idle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, x_in         evaluation request and its input vector (IDLE only)
//   busy, done, y_out   in-progress flag, one-cycle completion pulse, result
//   wr_en, wr_neuron,   weight/bias write (wr_idx == N_IN selects the bias)
//   wr_idx, wr_data
//   thr_wr_en, thr_data threshold write
//   wr_err              one-cycle pulse after a dropped write
module perceptron_layer_seq #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = W_W + $clog2(N_IN + 1),
    localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IW   = $clog2(N_IN + 1),
    localparam int IIW  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_IN-1:0]       x_in,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      y_out,
    input  logic                  wr_en,
    input  logic [NW-1:0]         wr_neuron,
    input  logic [IW-1:0]         wr_idx,
    input  logic signed [W_W-1:0] wr_data,
    input  logic                  thr_wr_en,
    input  logic signed [W_W-1:0] thr_data,
    output logic                  wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [N_IN-1:0]         x_q, x_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_fin;
    logic [NW-1:0]           n_q, n_d;
    logic [IW-1:0]           i_q, i_d;
    logic [N_OUT-1:0]        y_q, y_d;
    logic [N_OUT-1:0]        y_out_q, y_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wr_err_q, wr_err_d;
    logic signed [W_W-1:0]   w_q [N_OUT][N_IN];
    logic signed [W_W-1:0]   w_d [N_OUT][N_IN];
    logic signed [W_W-1:0]   b_q [N_OUT];
    logic signed [W_W-1:0]   b_d [N_OUT];
    logic signed [W_W-1:0]   thr_q, thr_d;
    logic                    idle, wr_ok;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_W-1:0] v);
        return {{(ACC_W - W_W){v[W_W-1]}}, v};
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        acc_d    = acc_q;
        n_d      = n_q;
        i_d      = i_q;
        y_d      = y_q;
        y_out_d  = y_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        w_d      = w_q;
        b_d      = b_q;
        thr_d    = thr_q;
        acc_fin  = acc_q + sext(b_q[n_q]);

        // Parameters may only change between evaluations; the cycle that shows
        // done is already IDLE, so writes are accepted there too.
        idle     = (state_q == S_IDLE);
        wr_ok    = wr_en && idle && (32'(wr_idx) <= N_IN) && (32'(wr_neuron) < N_OUT);
        wr_err_d = (wr_en && !wr_ok) || (thr_wr_en && !idle);

        if (wr_ok) begin
            if (wr_idx == IW'(N_IN)) b_d[wr_neuron] = wr_data;
            else                     w_d[wr_neuron][wr_idx[IIW-1:0]] = wr_data;
        end
        if (thr_wr_en && idle) thr_d = thr_data;

        case (state_q)
            S_IDLE: begin
                // done_q marks the completion cycle, in which start is ignored.
                if (start && !done_q) begin
                    x_d     = x_in;
                    acc_d   = '0;
                    n_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_q != IW'(N_IN)) begin
                    if (x_q[i_q[IIW-1:0]]) acc_d = acc_q + sext(w_q[n_q][i_q[IIW-1:0]]);
                    i_d = i_q + 1'b1;
                end else begin
                    // Bias cycle: finish the sum and resolve this neuron's bit.
                    y_d[n_q] = (acc_fin >= sext(thr_q));
                    acc_d    = '0;
                    i_d      = '0;
                    n_d      = n_q + 1'b1;
                    if (n_q == NW'(N_OUT - 1)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                y_out_d = y_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            i_q      <= '0;
            y_q      <= '0;
            y_out_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            w_q      <= '{default: '0};
            b_q      <= '{default: '0};
            thr_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            i_q      <= i_d;
            y_q      <= y_d;
            y_out_q  <= y_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            w_q      <= w_d;
            b_q      <= b_d;
            thr_q    <= thr_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign y_out  = y_out_q;
    assign wr_err = wr_err_q;

endmodule
